pulse_measure: RTL and testbench

Input-side counterpart of the pulse generator: measures the high width and rising-to-rising period of each pulse on a bit-bus input and queues the results for readout. Sits in the block layer alongside the pulse generator; its queue, overflow and missed-count status registers match the generator's, so the two can be looped back in simulation.

---
 rtl/pulse_pkg.sv | 22 ++
 rtl/pulse_meas_fifo.sv | 55 +++++
 rtl/pulse_measure.sv | 139 +++++++++++++
 tb/tb_pulse_measure.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_pkg.sv
// Shared definitions for the pulse generator / pulse measurement pair.
// Holds the default counter width, entry record and saturating increment.
package pulse_pkg;

   localparam int CNT_W_DEF = 48;

   typedef struct packed {
      logic [CNT_W_DEF-1:0] width;
      logic [CNT_W_DEF-1:0] period;
   } pulse_entry_t;

   // Increment that sticks at the all-ones value of a w-bit counter.
   function automatic logic [63:0] sat_inc(
      input logic [63:0] v,
      input int          w
   );
      logic [63:0] lim;
      lim = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
      return (v >= lim) ? lim : v + 64'd1;
   endfunction

endpackage

// File: rtl/pulse_meas_fifo.sv
// First-word-fall-through queue for measurement entries.
// Pointers carry an extra wrap bit to tell full from empty.
module pulse_meas_fifo #(
   parameter int DEPTH = 16,
   parameter int DW    = 96
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  logic [DW-1:0]            wdata,
   output logic [DW-1:0]            rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [DW-1:0] mem [DEPTH];
   logic [AW:0]   wr_ptr;
   logic [AW:0]   rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                  (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign count = wr_ptr - rd_ptr;

   // A pop in the same cycle frees the slot a full-queue push needs.
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= wdata;
   end

   assign rdata = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/pulse_measure.sv
// Measures high width and rise-to-rise period of pulses on inp_i
// and queues {width, period} entries for readout.
module pulse_measure
   import pulse_pkg::*;
#(
   parameter int FIFO_DEPTH = 16,
   parameter int CNT_W      = CNT_W_DEF
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             inp_i,
   input  logic             enable_i,
   input  logic             rd_stb_i,
   output logic             valid_o,
   output logic [CNT_W-1:0] WIDTH,
   output logic [CNT_W-1:0] PERIOD,
   output logic [31:0]      QUEUE,
   output logic [31:0]      ERR_OVERFLOW,
   output logic [31:0]      MISSED_CNT
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int DW = 2 * CNT_W;

   logic             inp_q;
   logic             inp_qq;
   logic             en_q;
   logic             armed;
   logic             first;
   logic [CNT_W-1:0] width_cnt;
   logic [CNT_W-1:0] period_cnt;
   logic [CNT_W-1:0] period_hold;
   logic             push_req;
   logic [DW-1:0]    push_data;
   logic [DW-1:0]    head;
   logic [DW-1:0]    last_head;
   logic [DW-1:0]    shown;
   logic [AW:0]      count;
   logic [31:0]      missed;
   logic             ovf;
   logic             full;
   logic             empty;
   logic             pop;
   logic             rise;
   logic             fall;
   logic             en_rise;

   function automatic logic [CNT_W-1:0] inc(input logic [CNT_W-1:0] v);
      return CNT_W'(sat_inc(64'(v), CNT_W));
   endfunction

   assign rise    = inp_q & ~inp_qq;
   assign fall    = ~inp_q & inp_qq;
   assign en_rise = enable_i & ~en_q;
   assign pop     = rd_stb_i & ~empty;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         inp_q       <= 1'b0;
         inp_qq      <= 1'b0;
         en_q        <= 1'b0;
         armed       <= 1'b0;
         first       <= 1'b1;
         width_cnt   <= '0;
         period_cnt  <= '0;
         period_hold <= '0;
         push_req    <= 1'b0;
         push_data   <= '0;
         missed      <= '0;
         ovf         <= 1'b0;
      end else begin
         inp_q    <= inp_i;
         inp_qq   <= inp_q;
         en_q     <= enable_i;
         push_req <= 1'b0;
         if (en_rise) begin
            // A pulse already high at enable is never armed.
            armed       <= ~inp_q;
            first       <= 1'b1;
            width_cnt   <= '0;
            period_cnt  <= '0;
            period_hold <= '0;
            missed      <= '0;
            ovf         <= 1'b0;
         end else begin
            if (enable_i) begin
               period_cnt <= rise ? '0 : inc(period_cnt);
               if (rise) begin
                  width_cnt   <= CNT_W'(1);
                  armed       <= 1'b1;
                  period_hold <= first ? '0 : inc(period_cnt);
                  first       <= 1'b0;
               end else if (inp_q) begin
                  width_cnt <= inc(width_cnt);
               end
               if (fall && armed) begin
                  push_req  <= 1'b1;
                  push_data <= {width_cnt, period_hold};
               end
            end
            if (push_req && full && !pop) begin
               missed <= 32'(sat_inc(64'(missed), 32));
               ovf    <= 1'b1;
            end
         end
      end
   end

   pulse_meas_fifo #(
      .DEPTH (FIFO_DEPTH),
      .DW    (DW)
   ) u_fifo (
      .clk   (clk_i),
      .rst   (reset_i),
      .push  (push_req & ~en_rise),
      .pop   (pop),
      .flush (en_rise),
      .wdata (push_data),
      .rdata (head),
      .full  (full),
      .empty (empty),
      .count (count)
   );

   // Head copy so WIDTH/PERIOD keep the last value once drained.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i)     last_head <= '0;
      else if (!empty) last_head <= head;
   end

   assign shown           = empty ? last_head : head;
   assign WIDTH           = shown[DW-1:CNT_W];
   assign PERIOD          = shown[CNT_W-1:0];
   assign valid_o         = ~empty;
   assign QUEUE           = 32'(count);
   assign ERR_OVERFLOW    = {31'b0, ovf};
   assign MISSED_CNT      = missed;

endmodule

// File: tb/tb_pulse_measure.sv
// Self-checking bench for pulse_measure: vector table, corner
// sequences and a random run against a queue-level reference model.
module tb_pulse_measure;
   import pulse_pkg::*;

   localparam int DEPTH = 16;

   logic        clk_i = 1'b0;
   logic        reset_i;
   logic        inp_i;
   logic        enable_i;
   logic        rd_stb_i;
   logic        valid_o;
   logic [47:0] WIDTH;
   logic [47:0] PERIOD;
   logic [31:0] QUEUE;
   logic [31:0] ERR_OVERFLOW;
   logic [31:0] MISSED_CNT;

   int checks   = 0;
   int failures = 0;

   pulse_measure #(
      .FIFO_DEPTH (DEPTH),
      .CNT_W      (48)
   ) dut (
      .clk_i        (clk_i),
      .reset_i      (reset_i),
      .inp_i        (inp_i),
      .enable_i     (enable_i),
      .rd_stb_i     (rd_stb_i),
      .valid_o      (valid_o),
      .WIDTH        (WIDTH),
      .PERIOD       (PERIOD),
      .QUEUE        (QUEUE),
      .ERR_OVERFLOW (ERR_OVERFLOW),
      .MISSED_CNT   (MISSED_CNT)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      int hi;
      int lo;
      int n;
      int exp_w;
      int exp_p;
   } vec_t;

   typedef struct {
      int           due;
      pulse_entry_t e;
   } pend_t;

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic check(input string nm, input logic [63:0] act,
                        input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic do_enable();
      inp_i    = 1'b0;
      enable_i = 1'b0;
      tick();
      tick();
      enable_i = 1'b1;
      tick();
   endtask

   task automatic pulse(input int h, input int l);
      inp_i = 1'b1;
      repeat (h) tick();
      inp_i = 1'b0;
      repeat (l) tick();
   endtask

   task automatic read_entry(input string nm, input int w, input int p);
      check({nm, "_valid"}, 64'(valid_o), 64'd1);
      check({nm, "_width"}, 64'(WIDTH), 64'(w));
      check({nm, "_period"}, 64'(PERIOD), 64'(p));
      rd_stb_i = 1'b1;
      tick();
      rd_stb_i = 1'b0;
   endtask

   vec_t vecs[5];

   initial begin
      pulse_entry_t q[$];
      pend_t        pend[$];
      pulse_entry_t e;
      pend_t        pe;
      logic         cur;
      logic         prev;
      logic         rd;
      logic         frst;
      int           t;
      int           prev_start;
      int           runleft;
      longint       run_w;
      longint       per;
      int           missed;
      int           ovf;

      vecs[0] = '{5, 3, 3, 5, 8};
      vecs[1] = '{1, 1, 4, 1, 2};
      vecs[2] = '{2, 5, 3, 2, 7};
      vecs[3] = '{7, 1, 2, 7, 8};
      vecs[4] = '{3, 3, 5, 3, 6};

      reset_i  = 1'b1;
      inp_i    = 1'b0;
      enable_i = 1'b0;
      rd_stb_i = 1'b0;
      repeat (3) tick();
      reset_i = 1'b0;
      tick();
      check("rst_valid", 64'(valid_o), 0);
      check("rst_queue", 64'(QUEUE), 0);
      check("rst_width", 64'(WIDTH), 0);
      check("rst_period", 64'(PERIOD), 0);
      check("rst_err", 64'(ERR_OVERFLOW), 0);
      check("rst_missed", 64'(MISSED_CNT), 0);

      // push latency: valid two edges after the falling sample
      do_enable();
      inp_i = 1'b1;
      repeat (5) tick();
      inp_i = 1'b0;
      tick();
      check("lat_n", 64'(valid_o), 0);
      tick();
      check("lat_n1", 64'(valid_o), 0);
      tick();
      check("lat_n2", 64'(valid_o), 1);
      check("lat_width", 64'(WIDTH), 5);
      check("lat_period", 64'(PERIOD), 0);

      foreach (vecs[v]) begin
         do_enable();
         for (int i = 0; i < vecs[v].n; i++)
            pulse(vecs[v].hi, vecs[v].lo);
         repeat (4) tick();
         check($sformatf("vec%0d_queue", v), 64'(QUEUE), 64'(vecs[v].n));
         for (int k = 0; k < vecs[v].n; k++)
            read_entry($sformatf("vec%0d_e%0d", v, k), vecs[v].exp_w,
                       (k == 0) ? 0 : vecs[v].exp_p);
         check($sformatf("vec%0d_empty", v), 64'(valid_o), 0);
         check($sformatf("vec%0d_hold", v), 64'(WIDTH),
               64'(vecs[v].exp_w));
      end

      // overflow: 20 pulses, widths 1..4 cycling, no reads
      do_enable();
      for (int i = 0; i < 20; i++) pulse(1 + i % 4, 2);
      repeat (4) tick();
      check("ovf_queue", 64'(QUEUE), 16);
      check("ovf_missed", 64'(MISSED_CNT), 4);
      check("ovf_err", 64'(ERR_OVERFLOW), 1);
      // push and pop on the same edge while full
      inp_i = 1'b1;
      repeat (3) tick();
      inp_i = 1'b0;
      tick();
      tick();
      rd_stb_i = 1'b1;
      tick();
      rd_stb_i = 1'b0;
      check("pp_queue", 64'(QUEUE), 16);
      check("pp_missed", 64'(MISSED_CNT), 4);
      check("pp_err", 64'(ERR_OVERFLOW), 1);
      for (int k = 1; k < 16; k++)
         read_entry($sformatf("ovf_e%0d", k), 1 + k % 4,
                    1 + (k - 1) % 4 + 2);
      read_entry("ovf_new", 3, 10);
      check("ovf_drained", 64'(valid_o), 0);
      do_enable();
      check("reen_queue", 64'(QUEUE), 0);
      check("reen_missed", 64'(MISSED_CNT), 0);
      check("reen_err", 64'(ERR_OVERFLOW), 0);

      // input already high when enable rises
      enable_i = 1'b0;
      tick();
      inp_i = 1'b1;
      tick();
      tick();
      enable_i = 1'b1;
      repeat (3) tick();
      inp_i = 1'b0;
      repeat (3) tick();
      pulse(2, 3);
      repeat (3) tick();
      check("enhi_queue", 64'(QUEUE), 1);
      read_entry("enhi_e0", 2, 0);
      check("enhi_empty", 64'(valid_o), 0);

      // enable dropped mid-pulse
      do_enable();
      pulse(3, 3);
      inp_i = 1'b1;
      tick();
      tick();
      enable_i = 1'b0;
      tick();
      tick();
      inp_i = 1'b0;
      repeat (4) tick();
      check("endrop_queue", 64'(QUEUE), 1);
      read_entry("endrop_e0", 3, 0);
      check("endrop_after", 64'(QUEUE), 0);

      // asynchronous reset mid-pulse with three entries queued
      do_enable();
      repeat (3) pulse(2, 2);
      repeat (3) tick();
      check("ar_pre_queue", 64'(QUEUE), 3);
      inp_i = 1'b1;
      tick();
      tick();
      #2 reset_i = 1'b1;
      #1;
      check("ar_valid", 64'(valid_o), 0);
      check("ar_queue", 64'(QUEUE), 0);
      check("ar_width", 64'(WIDTH), 0);
      check("ar_period", 64'(PERIOD), 0);
      check("ar_err", 64'(ERR_OVERFLOW), 0);
      check("ar_missed", 64'(MISSED_CNT), 0);
      inp_i = 1'b0;
      tick();
      reset_i = 1'b0;
      repeat (3) tick();
      check("ar_post_queue", 64'(QUEUE), 0);

      // random run against the reference model
      do_enable();
      cur        = 1'b0;
      prev       = 1'b0;
      frst       = 1'b1;
      t          = 0;
      prev_start = 0;
      runleft    = 0;
      run_w      = 0;
      per        = 0;
      missed     = 0;
      ovf        = 0;
      for (int cyc = 0; cyc < 600; cyc++) begin
         if (runleft == 0) begin
            cur     = ~cur;
            runleft = $urandom_range(1, 5);
         end
         runleft--;
         inp_i    = cur;
         rd       = ($urandom_range(0, 3) == 0);
         rd_stb_i = rd;
         tick();
         t++;
         if (rd && q.size() > 0) void'(q.pop_front());
         if (pend.size() > 0 && pend[0].due == t) begin
            pe = pend.pop_front();
            if (q.size() < DEPTH) q.push_back(pe.e);
            else begin
               missed++;
               ovf = 1;
            end
         end
         if (cur && !prev) begin
            per        = frst ? 0 : longint'(t - prev_start);
            frst       = 1'b0;
            prev_start = t;
            run_w      = 1;
         end else if (cur) begin
            run_w++;
         end
         if (!cur && prev) begin
            e.width  = 48'(run_w);
            e.period = 48'(per);
            pend.push_back('{t + 2, e});
         end
         prev = cur;
         check($sformatf("rnd%0d_valid", cyc), 64'(valid_o),
               64'(q.size() > 0));
         check($sformatf("rnd%0d_queue", cyc), 64'(QUEUE), 64'(q.size()));
         check($sformatf("rnd%0d_missed", cyc), 64'(MISSED_CNT),
               64'(missed));
         check($sformatf("rnd%0d_err", cyc), 64'(ERR_OVERFLOW), 64'(ovf));
         if (q.size() > 0) begin
            check($sformatf("rnd%0d_width", cyc), 64'(WIDTH),
                  64'(q[0].width));
            check($sformatf("rnd%0d_period", cyc), 64'(PERIOD),
                  64'(q[0].period));
         end
      end
      rd_stb_i = 1'b0;
      inp_i    = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
